// File: rtl/i2c_slave_link.sv
// I2C slave moving fixed-length packets of 32-bit words between the bus and a receive/transmit FIFO pair.
// state | meaning: IDLE wait START | ADDR shift address | ADDR_ACK ack address | WR_DATA/WR_ACK take byte/ack it
//   RD_DATA/RD_ACK send byte/sample master ack | WAIT_STOP ignore bus until STOP or START
`timescale 1ns/1ps
module i2c_slave_link #(
  parameter int PKG_LEN = 10,
  parameter int FILT    = 3
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        scl_pin,
  inout  wire         sda_pin,
  input  logic [6:0]  reg_addr,
  output logic        reg_wstop,
  output logic        reg_rstop,
  output logic        reg_rerr,
  input  logic        full,
  output logic        push,
  output logic [31:0] dout,
  input  logic        empty,
  output logic        pop,
  input  logic [31:0] din
);

  localparam int BYTES = 4 * PKG_LEN;
  localparam int BCW   = $clog2(BYTES + 2);
  localparam int FW    = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [BCW-1:0] BYTES_C  = BCW'(BYTES);
  localparam logic [BCW-1:0] BYTES_C1 = BCW'(BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0]     sync1, sync2, filt, filt_d;
  logic [FW-1:0]  fcnt [2];
  logic           scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  state_t         state;
  logic [3:0]     bit_cnt;
  logic [7:0]     rx_sr;
  logic [7:0]     rx_byte;
  logic [23:0]    word_sr;
  logic [31:0]    tx_sr;
  logic [BCW-1:0] byte_cnt;
  logic           ack_en, wr_txn, rd_txn, rd_done, pop_d, sda_oe;

  assign sda_pin = sda_oe ? 1'b0 : 1'bz;

  // index 0 is SCL, index 1 is SDA; a new level is taken after FILT consecutive differing samples
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sync1   <= '1;
      sync2   <= '1;
      filt    <= '1;
      filt_d  <= '1;
      fcnt[0] <= FW'(FILT - 1);
      fcnt[1] <= FW'(FILT - 1);
    end else begin
      sync1  <= {sda_pin, scl_pin};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= FW'(FILT - 1);
        end else if (fcnt[i] == '0) begin
          filt[i] <= sync2[i];
          fcnt[i] <= FW'(FILT - 1);
        end else begin
          fcnt[i] <= fcnt[i] - 1'b1;
        end
      end
    end
  end

  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_rise  = scl_f & ~filt_d[0];
  assign scl_fall  = ~scl_f & filt_d[0];
  assign start_det = scl_f & filt_d[0] & filt_d[1] & ~sda_f;
  assign stop_det  = scl_f & filt_d[0] & ~filt_d[1] & sda_f;
  assign rx_byte   = {rx_sr[6:0], sda_f};

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      word_sr   <= '0;
      tx_sr     <= '0;
      byte_cnt  <= '0;
      ack_en    <= 1'b0;
      wr_txn    <= 1'b0;
      rd_txn    <= 1'b0;
      rd_done   <= 1'b0;
      pop_d     <= 1'b0;
      sda_oe    <= 1'b0;
      push      <= 1'b0;
      pop       <= 1'b0;
      dout      <= '0;
      reg_wstop <= 1'b0;
      reg_rstop <= 1'b0;
      reg_rerr  <= 1'b0;
    end else begin
      push      <= 1'b0;
      pop       <= 1'b0;
      reg_wstop <= 1'b0;
      reg_rstop <= 1'b0;
      reg_rerr  <= 1'b0;
      pop_d     <= pop;
      if (start_det || stop_det) begin
        if (rd_txn) begin
          reg_rstop <= rd_done;
          reg_rerr  <= ~rd_done;
        end
        if (wr_txn && stop_det) reg_wstop <= (byte_cnt == BYTES_C);
        wr_txn   <= 1'b0;
        rd_txn   <= 1'b0;
        rd_done  <= 1'b0;
        sda_oe   <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        state    <= start_det ? ADDR : IDLE;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (rx_byte[7:1] == reg_addr && (rx_byte[0] ? !empty : !full)) begin
                state   <= ADDR_ACK;
                bit_cnt <= 4'd8;
                if (rx_byte[0]) begin
                  rd_txn <= 1'b1;
                  pop    <= 1'b1;
                end else begin
                  wr_txn <= 1'b1;
                end
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
            end else begin
              bit_cnt <= '0;
              if (rd_txn) begin
                sda_oe <= ~tx_sr[31];
                state  <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end else if (scl_rise) begin
            bit_cnt <= 4'd9;
          end
          WR_DATA: if (scl_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state   <= WR_ACK;
              bit_cnt <= 4'd8;
              ack_en  <= (byte_cnt < BYTES_C);
              if (byte_cnt != BYTES_C1) byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt < BYTES_C) begin
                word_sr <= {word_sr[15:0], rx_byte};
                if (byte_cnt[1:0] == 2'd3) begin
                  push <= 1'b1;
                  dout <= {word_sr, rx_byte};
                end
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= ack_en;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WR_DATA;
            end
          end else if (scl_rise) begin
            bit_cnt <= 4'd9;
          end
          RD_DATA: if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state   <= RD_ACK;
              bit_cnt <= 4'd8;
              if (byte_cnt != BYTES_C1) byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (scl_fall) begin
            tx_sr  <= {tx_sr[30:0], 1'b0};
            sda_oe <= ~tx_sr[30];
          end
          RD_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              tx_sr  <= {tx_sr[30:0], 1'b0};
              sda_oe <= 1'b0;
            end else begin
              bit_cnt <= '0;
              sda_oe  <= ~tx_sr[31];
              state   <= RD_DATA;
            end
          end else if (scl_rise && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd9;
            if (sda_f) begin
              state   <= WAIT_STOP;
              rd_done <= (byte_cnt == BYTES_C);
            end else if (byte_cnt[1:0] == 2'd0 && byte_cnt < BYTES_C) begin
              pop <= 1'b1;
            end
          end
          IDLE, WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
      // next word arrives one cycle after pop; it must win over any shift in this cycle
      if (pop_d) tx_sr <= din;
    end
  end

endmodule

// File: tb/tb_i2c_slave_link.sv
// Bench for i2c_slave_link: an I2C master model with a FIFO model on each side, table-driven transactions.
`timescale 1ns/1ps
module tb_i2c_slave_link;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [6:0]  reg_addr = 7'h3B;
  logic        full = 1'b0;
  logic        empty = 1'b0;
  logic [31:0] din = '0;
  logic        reg_wstop, reg_rstop, reg_rerr, push, pop;
  logic [31:0] dout;
  wire         sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_link dut (
    .CLK_I(clk), .RST_I(rst), .scl_pin(m_scl), .sda_pin(sda_bus), .reg_addr(reg_addr),
    .reg_wstop(reg_wstop), .reg_rstop(reg_rstop), .reg_rerr(reg_rerr),
    .full(full), .push(push), .dout(dout), .empty(empty), .pop(pop), .din(din)
  );

  int rd_cnt = 0;
  int rd_base = 0;
  always @(posedge clk) begin
    if (pop) begin
      din    <= 32'hA0B0C000 + 32'(rd_cnt - rd_base);
      rd_cnt <= rd_cnt + 1;
    end
  end

  int push_cnt = 0, pop_cnt = 0, wstop_cnt = 0, rstop_cnt = 0, rerr_cnt = 0, overlap_cnt = 0;
  logic [31:0] push_q [$];
  always @(negedge clk) begin
    if (push) begin
      push_cnt <= push_cnt + 1;
      push_q.push_back(dout);
    end
    if (pop)          pop_cnt     <= pop_cnt + 1;
    if (reg_wstop)    wstop_cnt   <= wstop_cnt + 1;
    if (reg_rstop)    rstop_cnt   <= rstop_cnt + 1;
    if (reg_rerr)     rerr_cnt    <= rerr_cnt + 1;
    if (push && pop)  overlap_cnt <= overlap_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wt(Q); m_sda = 1'b1;
    wt(Q); m_scl = 1'b1;
    wt(Q); m_sda = 1'b0;
    wt(Q); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wt(Q); m_sda = 1'b0;
    wt(Q); m_scl = 1'b1;
    wt(Q); m_sda = 1'b1;
    wt(Q);
  endtask

  task automatic send_bit(input logic b, output logic s);
    wt(Q); m_sda = b;
    wt(Q); m_scl = 1'b1;
    wt(Q); s = sda_bus;
    wt(Q); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(~ack, s);
  endtask

  typedef struct {
    logic [7:0] addr;
    int         nbytes;
    logic       full_i;
    logic       empty_i;
    logic       exp_ack;
    int         exp_dacks;
    int         exp_push;
    int         exp_pop;
    int         exp_wstop;
    int         exp_rstop;
    int         exp_rerr;
    logic       chk_status;
  } vec_t;

  vec_t vecs [8];

  task automatic run_txn(input vec_t v, input int idx);
    int p0, q0, w0, r0, e0, o0, qn, dacks, bad;
    logic ack, a;
    logic [7:0] b, eb;
    logic [31:0] w, ew;
    p0 = push_cnt; q0 = pop_cnt; w0 = wstop_cnt; r0 = rstop_cnt; e0 = rerr_cnt; o0 = overlap_cnt;
    qn = push_q.size();
    rd_base = rd_cnt;
    full = v.full_i;
    empty = v.empty_i;
    dacks = 0;
    bad = 0;
    i2c_start();
    send_byte(v.addr, ack);
    chk($sformatf("v%0d_addr_ack", idx), 32'(ack), 32'(v.exp_ack));
    if (ack && !v.addr[0]) begin
      for (int i = 0; i < v.nbytes; i++) begin
        send_byte(8'(i), a);
        if (a) dacks++;
      end
      chk($sformatf("v%0d_data_acks", idx), 32'(dacks), 32'(v.exp_dacks));
      for (int j = 0; j < push_q.size() - qn; j++) begin
        ew = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
        if (push_q[qn+j] !== ew) bad++;
      end
      chk($sformatf("v%0d_wr_words_bad", idx), 32'(bad), 32'd0);
    end else if (ack) begin
      for (int i = 0; i < v.nbytes; i++) begin
        recv_byte(i != v.nbytes - 1, b);
        w  = 32'hA0B0C000 + 32'(i / 4);
        eb = w[31 - 8*(i % 4) -: 8];
        if (b !== eb) bad++;
      end
      chk($sformatf("v%0d_rd_bytes_bad", idx), 32'(bad), 32'd0);
      wt(Q);
      chk($sformatf("v%0d_sda_released", idx), 32'(sda_bus), 32'd1);
    end
    i2c_stop();
    wt(40);
    full = 1'b0;
    empty = 1'b0;
    chk($sformatf("v%0d_push", idx), 32'(push_cnt - p0), 32'(v.exp_push));
    chk($sformatf("v%0d_pop", idx), 32'(pop_cnt - q0), 32'(v.exp_pop));
    chk($sformatf("v%0d_overlap", idx), 32'(overlap_cnt - o0), 32'd0);
    if (v.chk_status) begin
      chk($sformatf("v%0d_wstop", idx), 32'(wstop_cnt - w0), 32'(v.exp_wstop));
      chk($sformatf("v%0d_rstop", idx), 32'(rstop_cnt - r0), 32'(v.exp_rstop));
      chk($sformatf("v%0d_rerr", idx), 32'(rerr_cnt - e0), 32'(v.exp_rerr));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int p0, w0;
    logic a, s;
    logic [7:0] byte6;

    //          addr   n   full  empty ack  dacks push pop ws rs re chk
    vecs[0] = '{8'h76, 40, 1'b0, 1'b0, 1'b1, 40, 10, 0,  1, 0, 0, 1'b1};
    vecs[1] = '{8'h78, 0,  1'b0, 1'b0, 1'b0, 0,  0,  0,  0, 0, 0, 1'b1};
    vecs[2] = '{8'h77, 40, 1'b0, 1'b0, 1'b1, 0,  0,  10, 0, 1, 0, 1'b1};
    vecs[3] = '{8'h77, 5,  1'b0, 1'b0, 1'b1, 0,  0,  2,  0, 0, 1, 1'b1};
    vecs[4] = '{8'h76, 0,  1'b1, 1'b0, 1'b0, 0,  0,  0,  0, 0, 0, 1'b1};
    vecs[5] = '{8'h76, 6,  1'b0, 1'b0, 1'b1, 6,  1,  0,  0, 0, 0, 1'b1};
    vecs[6] = '{8'h76, 41, 1'b0, 1'b0, 1'b1, 40, 10, 0,  0, 0, 0, 1'b0};
    vecs[7] = '{8'h77, 0,  1'b0, 1'b1, 1'b0, 0,  0,  0,  0, 0, 0, 1'b1};

    wt(5);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_status", {29'd0, reg_wstop, reg_rstop, reg_rerr}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_sda", 32'(sda_bus), 32'd1);
    rst = 1'b0;
    wt(10);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], i);
      if (i == 0) begin
        chk("v0_first_word", push_q[0], 32'h00010203);
        chk("v0_last_word", push_q[9], 32'h24252627);
      end
    end

    // reset while the slave is acknowledging byte 7 of a write
    p0 = push_cnt;
    w0 = wstop_cnt;
    i2c_start();
    send_byte(8'h76, a);
    chk("rst_seq_addr_ack", 32'(a), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(8'(i), a);
    byte6 = 8'h06;
    for (int i = 7; i >= 0; i--) send_bit(byte6[i], s);
    wt(Q); m_sda = 1'b1;
    wt(1);
    chk("rst_seq_ack_driven", 32'(sda_bus), 32'd0);
    wt(Q - 1); m_scl = 1'b1;
    wt(Q / 2);
    rst = 1'b1;
    #1;
    chk("rst_seq_sda_released", 32'(sda_bus), 32'd1);
    wt(3);
    rst = 1'b0;
    wt(Q); m_scl = 1'b0;
    send_byte(8'h07, a);
    chk("rst_seq_post_nack", 32'(a), 32'd0);
    send_byte(8'h08, a);
    i2c_stop();
    wt(40);
    chk("rst_seq_push", 32'(push_cnt - p0), 32'd1);
    chk("rst_seq_word", push_q[push_q.size() - 1], 32'h00010203);
    chk("rst_seq_wstop", 32'(wstop_cnt - w0), 32'd0);

    run_txn(vecs[0], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
